// File: rtl/arb8way16.sv
// rtl/arb8way16.sv - 8-way round-robin arbiter with hold limit and 16-bit data mux
//
// Ports:
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   req[7:0]     : level-sensitive request lines, bit i = requester i
//   a..h[15:0]   : data words of requesters 0..7
//   gnt[7:0]     : registered one-hot grant (or zero)
//   sel[2:0]     : registered index of the current owner
//   valid        : registered, high while a grant is active
//   out[15:0]    : combinational data word of the owner, zero when not valid
module arb8way16 #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic        valid,
  output logic [15:0] out
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      state_q;
  logic [2:0]  last_q;
  logic [3:0]  cnt_q;
  logic [7:0]  gnt_q;
  logic [2:0]  sel_q;
  logic        valid_q;

  logic [2:0]  base_d;
  logic [2:0]  winner_d;
  logic        release_d;
  logic [15:0] out_d;

  // Scan base: in GRANT a release writes last<=sel, so the winner for that
  // same edge must be computed from sel rather than the stale last.
  always_comb begin
    base_d = (state_q == ST_GRANT) ? sel_q : last_q;
  end

  // First set request scanning base+1 .. base+8 (mod 8). Iterating from the
  // far end down lets the nearest hit overwrite farther ones.
  always_comb begin
    logic [2:0] idx;
    winner_d = base_d;
    for (int k = 8; k >= 1; k--) begin
      idx = base_d + 3'(k);
      if (req[idx]) begin
        winner_d = idx;
      end
    end
  end

  always_comb begin
    release_d = (req[sel_q] == 1'b0) || (cnt_q >= 4'(MAX_HOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 3'd7;
      cnt_q   <= 4'd0;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req != 8'h00) begin
            state_q <= ST_GRANT;
            gnt_q   <= 8'h01 << winner_d;
            sel_q   <= winner_d;
            valid_q <= 1'b1;
            cnt_q   <= 4'd1;
          end else begin
            gnt_q   <= 8'h00;
            valid_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!release_d) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            last_q <= sel_q;
            if (req != 8'h00) begin
              // Back-to-back handover; a still-requesting owner only wins
              // when the scan wraps all the way round to itself.
              gnt_q   <= 8'h01 << winner_d;
              sel_q   <= winner_d;
              valid_q <= 1'b1;
              cnt_q   <= 4'd1;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= 8'h00;
              valid_q <= 1'b0;
              cnt_q   <= 4'd0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 8'h00;
          valid_q <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    case (sel_q)
      3'd0:    out_d = a;
      3'd1:    out_d = b;
      3'd2:    out_d = c;
      3'd3:    out_d = d;
      3'd4:    out_d = e;
      3'd5:    out_d = f;
      3'd6:    out_d = g;
      default: out_d = h;
    endcase
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign out   = valid_q ? out_d : 16'h0000;

endmodule

// File: tb/tb_arb8way16.sv
// tb/tb_arb8way16.sv - directed self-checking bench for arb8way16
module tb_arb8way16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic        valid;
  logic [15:0] out;

  int tests_run;
  int tests_failed;

  logic [15:0] words [8];
  logic [7:0]  one;

  arb8way16 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .h     (h),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_owner(input string tag, input int idx);
    one = 8'h01;
    check({tag, "_gnt"}, 32'(gnt), 32'(one << idx));
    check({tag, "_sel"}, 32'(sel), 32'(idx));
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_out"}, 32'(out), 32'(words[idx]));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h00);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_out"}, 32'(out), 32'h0000);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    words[0] = 16'hAAAA; words[1] = 16'h0000; words[2] = 16'h1111; words[3] = 16'h4444;
    words[4] = 16'hCCCC; words[5] = 16'hFFFF; words[6] = 16'hDDDD; words[7] = 16'hEEEE;
    a = words[0]; b = words[1]; c = words[2]; d = words[3];
    e = words[4]; f = words[5]; g = words[6]; h = words[7];
    rst_n = 1'b0;
    req   = 8'h00;

    // reset state
    step();
    expect_idle("rst");
    check("rst_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;

    // no requests for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("noreq");
    end

    // all requesting: 0..7 then 0, 4 cycles each
    req = 8'hFF;
    for (int cyc = 0; cyc < 36; cyc++) begin
      step();
      expect_owner("rr", (cyc / 4) % 8);
    end
    req = 8'h00;
    step();
    expect_idle("rr_end");

    // single requester 3 then idle, then 0 wins over 3 from last=3
    req = 8'h08;
    step();
    expect_owner("r3a", 3);
    step();
    expect_owner("r3b", 3);
    req = 8'h00;
    step();
    expect_idle("r3_idle");
    req = 8'h09;
    step();
    expect_owner("wrap0", 0);
    req = 8'h00;
    step();
    expect_idle("wrap0_idle");

    // owner 5 drops as 2 raises: handover without idle bubble
    req = 8'h20;
    step();
    expect_owner("own5", 5);
    req = 8'h04;
    step();
    expect_owner("hand2", 2);
    req = 8'h00;
    step();
    expect_idle("hand_idle");

    // lone requester 6 is regranted across hold boundaries
    req = 8'h40;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_owner("solo6", 6);
    end
    req = 8'h00;
    step();
    expect_idle("solo_idle");

    // async reset in the middle of requester 4's grant
    req = 8'h10;
    step();
    expect_owner("own4", 4);
    step();
    expect_owner("own4b", 4);
    rst_n = 1'b0;
    #1;
    expect_idle("async_rst");
    req = 8'h11;
    step();
    expect_idle("rst_held");
    rst_n = 1'b1;
    step();
    expect_owner("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
